// File: rtl/lmem_port_arbiter.sv
// Two-port arbiter for the shared layer-memory port: round-robin with bounded burst hold,
// registered command issue, and read data returned to the issuing port one cycle after access.
module lmem_port_arbiter #(
    parameter int unsigned AW        = 12,
    parameter int unsigned DW        = 20,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [2:0]    sel0,
    input  logic [2:0]    sel1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wd0,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rv0,
    output logic          rv1,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic          cwr,
    output logic          crd,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel,
    input  logic [DW-1:0] cdata_rd
);

    localparam int unsigned CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t        owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          any_c;
    logic          win_c;
    logic          keep_c;

    logic          cmd_we_c;
    logic [2:0]    cmd_sel_c;
    logic [AW-1:0] cmd_addr_c;
    logic [DW-1:0] cmd_wd_c;

    logic          tag_q;

    // Winner selection and owner/burst bookkeeping
    always_comb begin
        owner_d = OWN_NONE;
        last_d  = last_q;
        cnt_d   = '0;
        any_c   = 1'b0;
        win_c   = 1'b0;
        keep_c  = (owner_q != OWN_NONE) && (cnt_q < CW'(MAX_BURST));

        if (req0 && req1) begin
            any_c = 1'b1;
            win_c = keep_c ? (owner_q == OWN_P1) : ~last_q;
        end else if (req0) begin
            any_c = 1'b1;
            win_c = 1'b0;
        end else if (req1) begin
            any_c = 1'b1;
            win_c = 1'b1;
        end

        if (any_c) begin
            owner_d = win_c ? OWN_P1 : OWN_P0;
            last_d  = win_c;
            if (owner_q == owner_d) begin
                cnt_d = (cnt_q < CW'(MAX_BURST)) ? cnt_q + CW'(1) : cnt_q;
            end else begin
                cnt_d = CW'(1);
            end
        end
    end

    assign gnt0 = any_c & ~win_c & ~reset;
    assign gnt1 = any_c &  win_c & ~reset;

    assign cmd_we_c   = win_c ? we1   : we0;
    assign cmd_sel_c  = win_c ? sel1  : sel0;
    assign cmd_addr_c = win_c ? addr1 : addr0;
    assign cmd_wd_c   = win_c ? wd1   : wd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Command issue; addresses and write data hold between commands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr      <= 1'b0;
            crd      <= 1'b0;
            csel     <= '0;
            caddr_wr <= '0;
            caddr_rd <= '0;
            cdata_wr <= '0;
            tag_q    <= 1'b0;
        end else begin
            cwr   <= any_c &  cmd_we_c;
            crd   <= any_c & ~cmd_we_c;
            csel  <= any_c ? cmd_sel_c : 3'd0;
            tag_q <= win_c;
            if (any_c && cmd_we_c) begin
                caddr_wr <= cmd_addr_c;
                cdata_wr <= cmd_wd_c;
            end
            if (any_c && !cmd_we_c) begin
                caddr_rd <= cmd_addr_c;
            end
        end
    end

    // Read return: tag selects which port captures the memory data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rv0 <= 1'b0;
            rv1 <= 1'b0;
            rd0 <= '0;
            rd1 <= '0;
        end else begin
            rv0 <= crd & ~tag_q;
            rv1 <= crd &  tag_q;
            if (crd && !tag_q) begin
                rd0 <= cdata_rd;
            end
            if (crd && tag_q) begin
                rd1 <= cdata_rd;
            end
        end
    end

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// Bench for lmem_port_arbiter: vector table with expected grants, scoreboard queues for
// issued commands and read returns, backed by a behavioural memory and a shadow copy.
module tb_lmem_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 20;
    localparam logic [1:0]  GN = 2'b00;
    localparam logic [1:0]  G0 = 2'b01;
    localparam logic [1:0]  G1 = 2'b10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [2:0]    sel0 = '0, sel1 = '0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wd0 = '0, wd1 = '0;
    logic          gnt0, gnt1, rv0, rv1, cwr, crd;
    logic [DW-1:0] rd0, rd1, cdata_wr, cdata_rd;
    logic [AW-1:0] caddr_wr, caddr_rd;
    logic [2:0]    csel;

    always #5 clk = ~clk;

    lmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .sel0(sel0), .sel1(sel1), .addr0(addr0), .addr1(addr1),
        .wd0(wd0), .wd1(wd1), .gnt0(gnt0), .gnt1(gnt1),
        .rv0(rv0), .rv1(rv1), .rd0(rd0), .rd1(rd1),
        .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .csel(csel), .cdata_rd(cdata_rd)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 12'h041) return 20'h0ABCD;
        return DW'(a) ^ 20'h5A5A5;
    endfunction

    // Behavioural memory: write at clock edge, read data combinational while crd is high
    logic [DW-1:0] mem [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = init_val(AW'(i));
        forever begin
            @(posedge clk);
            if (cwr) mem[caddr_wr] = cdata_wr;
        end
    end
    assign cdata_rd = crd ? mem[caddr_rd] : '0;

    typedef struct {
        logic          rst;
        logic          r0, w0;
        logic [2:0]    s0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [2:0]    s1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic [1:0]    eg;
    } vec_t;

    typedef struct {
        logic          v, we, port;
        logic [2:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } iss_t;

    typedef struct {
        logic          v, port;
        logic [DW-1:0] data;
    } ret_t;

    vec_t vecs[$];
    iss_t iss_q[$];
    ret_t ret_q[$];

    logic [DW-1:0] shadow [0:4095];
    logic [AW-1:0] exp_caddr_wr, exp_caddr_rd;
    logic [DW-1:0] exp_cdata_wr, exp_rd0, exp_rd1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic rst,
                       input logic r0, input logic w0, input logic [2:0] s0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic [2:0] s1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [1:0] eg);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.s0 = s0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.s1 = s1; v.a1 = a1; v.d1 = d1; v.eg = eg;
        vecs.push_back(v);
    endtask

    task automatic add_idle();
        add(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0, GN);
    endtask

    task automatic clear_expect();
        iss_q.delete();
        ret_q.delete();
        exp_caddr_wr = '0;
        exp_caddr_rd = '0;
        exp_cdata_wr = '0;
        exp_rd0      = '0;
        exp_rd1      = '0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_gnt0", gnt0, 0);         chk("rst_gnt1", gnt1, 0);
        chk("rst_rv0", rv0, 0);           chk("rst_rv1", rv1, 0);
        chk("rst_rd0", rd0, 0);           chk("rst_rd1", rd1, 0);
        chk("rst_cwr", cwr, 0);           chk("rst_crd", crd, 0);
        chk("rst_caddr_wr", caddr_wr, 0); chk("rst_caddr_rd", caddr_rd, 0);
        chk("rst_cdata_wr", cdata_wr, 0); chk("rst_csel", csel, 0);
    endtask

    task automatic drive_idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        sel0 = '0; sel1 = '0; addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        #1;
        chk_reset_outs();
        @(negedge clk);
        reset = 1'b0;
        clear_expect();
    endtask

    // Pop the command expected this cycle and the read return expected from last cycle
    task automatic check_issue();
        iss_t e;
        ret_t r, n;
        e = iss_q.pop_front();
        chk("cwr", cwr, e.v & e.we);
        chk("crd", crd, e.v & ~e.we);
        chk("csel", csel, e.v ? e.sel : 3'd0);
        if (e.v && e.we) begin
            exp_caddr_wr = e.addr;
            exp_cdata_wr = e.wd;
        end
        if (e.v && !e.we) exp_caddr_rd = e.addr;
        chk("caddr_wr", caddr_wr, exp_caddr_wr);
        chk("caddr_rd", caddr_rd, exp_caddr_rd);
        chk("cdata_wr", cdata_wr, exp_cdata_wr);

        r.v = 0; r.port = 0; r.data = '0;
        if (ret_q.size() > 0) r = ret_q.pop_front();
        chk("rv0", rv0, r.v & ~r.port);
        chk("rv1", rv1, r.v & r.port);
        if (r.v && r.port)  exp_rd1 = r.data;
        if (r.v && !r.port) exp_rd0 = r.data;
        chk("rd0", rd0, exp_rd0);
        chk("rd1", rd1, exp_rd1);

        n.v    = e.v & ~e.we;
        n.port = e.port;
        n.data = shadow[e.addr];
        if (e.v && e.we) shadow[e.addr] = e.wd;
        ret_q.push_back(n);
    endtask

    task automatic step(input vec_t v);
        iss_t e;
        @(negedge clk);
        req0 = v.r0; we0 = v.w0; sel0 = v.s0; addr0 = v.a0; wd0 = v.d0;
        req1 = v.r1; we1 = v.w1; sel1 = v.s1; addr1 = v.a1; wd1 = v.d1;
        #1;
        chk("gnt", {30'd0, gnt1, gnt0}, {30'd0, v.eg});
        e.v    = (v.eg != GN);
        e.port = v.eg[1];
        e.we   = v.eg[1] ? v.w1 : v.w0;
        e.sel  = v.eg[1] ? v.s1 : v.s0;
        e.addr = v.eg[1] ? v.a1 : v.a0;
        e.wd   = v.eg[1] ? v.d1 : v.d0;
        iss_q.push_back(e);
        @(posedge clk);
        #1;
        check_issue();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) shadow[i] = init_val(AW'(i));
        clear_expect();

        // single write, then idle
        add(1, 1, 1, 3'd1, 12'h005, 20'h01310, 0, 0, 0, '0, '0, G0);
        add_idle(); add_idle();
        // port 1 read returning 0x0ABCD
        add(0, 0, 0, 0, '0, '0, 1, 0, 3'd1, 12'h041, '0, G1);
        add_idle(); add_idle();
        // port 0 back-to-back reads: rv0 overlaps the second grant
        add(0, 1, 0, 3'd2, 12'h005, '0, 0, 0, 0, '0, '0, G0);
        add(0, 1, 0, 3'd3, 12'h041, '0, 0, 0, 0, '0, '0, G0);
        add_idle(); add_idle();
        // both requesting from reset
        for (int i = 0; i < 12; i++)
            add(i == 0, 1, 1, 3'd4, 12'h200, 20'h11111, 1, 0, 3'd5, 12'h300, '0,
                (i >= 4 && i < 8) ? G1 : G0);
        add_idle();
        // port 1 alone saturates its burst count, then port 0 joins
        for (int i = 0; i < 6; i++)
            add(0, 0, 0, 0, '0, '0, 1, 1, 3'd6, 12'h3F0 + AW'(i), 20'hA0000 + DW'(i), G1);
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 3'd7, 12'h3F2, '0, 1, 0, 3'd2, 12'h3F5, '0, (i < 4) ? G0 : G1);
        add_idle(); add_idle();
        // read / write / read of the same address on port 1
        add(0, 0, 0, 0, '0, '0, 1, 0, 3'd1, 12'h100, '0, G1);
        add(0, 0, 0, 0, '0, '0, 1, 1, 3'd1, 12'h100, 20'h00042, G1);
        add(0, 0, 0, 0, '0, '0, 1, 0, 3'd1, 12'h100, '0, G1);
        add_idle(); add_idle(); add_idle();
        // port 1 write loses and is dropped; its address must stay untouched
        add(0, 1, 0, 3'd2, 12'h005, '0, 1, 1, 3'd3, 12'h7FF, 20'hFFFFF, G0);
        add_idle();
        add(0, 0, 0, 0, '0, '0, 1, 0, 3'd3, 12'h7FF, '0, G1);
        add_idle(); add_idle();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step(vecs[i]);
        end

        // reset asserted while a read is on the memory port
        clear_expect();
        @(negedge clk);
        req1 = 1; we1 = 0; sel1 = 3'd6; addr1 = 12'h041;
        #1;
        chk("mid_gnt1", gnt1, 1);
        @(posedge clk);
        #1;
        chk("mid_crd", crd, 1);
        chk("mid_caddr_rd", caddr_rd, 12'h041);
        drive_idle();
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rv0", rv0, 0);
            chk("post_rv1", rv1, 0);
            chk("post_crd", crd, 0);
            chk("post_rd1", rd1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
